// File: rtl/arb_rr_2x8.sv
// Two-source round-robin arbiter feeding a single registered 8-bit output slot.
// Define ARB_FIXED_PRIO_EN to replace round robin with fixed priority to source 0.
module arb_rr_2x8 (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a0,
  input  logic       a0_valid,
  output logic       a0_ready,
  input  logic [7:0] a1,
  input  logic       a1_valid,
  output logic       a1_ready,
  output logic       sel,
  output logic [7:0] out,
  output logic       out_valid,
  input  logic       out_ready
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t     state_r;
  state_t     state_nxt_s;
  logic       load_ok_s;
  logic       grant_valid_s;
  logic       grant_idx_s;
  logic       pri_s;
  logic       take_s;
  logic [7:0] out_r;
  logic       sel_r;
  logic       out_valid_r;

`ifdef ARB_FIXED_PRIO_EN
  assign pri_s = 1'b0;
`else
  logic ptr_r;

  // Round-robin pointer: after serving a channel, favour the other one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= 1'b0;
    end else if (take_s) begin
      ptr_r <= ~grant_idx_s;
    end
  end

  assign pri_s = ptr_r;
`endif

  // Grant selection among the valid sources.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_idx_s   = 1'b0;
    case ({a1_valid, a0_valid})
      2'b01: begin
        grant_valid_s = 1'b1;
        grant_idx_s   = 1'b0;
      end
      2'b10: begin
        grant_valid_s = 1'b1;
        grant_idx_s   = 1'b1;
      end
      2'b11: begin
        grant_valid_s = 1'b1;
        grant_idx_s   = pri_s;
      end
      default: begin
        grant_valid_s = 1'b0;
        grant_idx_s   = 1'b0;
      end
    endcase
  end

  // Slot is free when empty, or when the held word leaves this cycle.
  always_comb begin
    load_ok_s = 1'b0;
    case (state_r)
      EMPTY:   load_ok_s = 1'b1;
      FULL:    load_ok_s = out_ready;
      default: load_ok_s = 1'b0;
    endcase
  end

  // Ready is gated by reset so no transfer is advertised while reset is held.
  assign a0_ready = load_ok_s & grant_valid_s & ~grant_idx_s & ~rst;
  assign a1_ready = load_ok_s & grant_valid_s &  grant_idx_s & ~rst;
  assign take_s   = a0_ready | a1_ready;

  // Next-state logic for the output slot.
  always_comb begin
    state_nxt_s = state_r;
    if (take_s) begin
      state_nxt_s = FULL;
    end else if ((state_r == FULL) && out_ready) begin
      state_nxt_s = EMPTY;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Slot state and its valid flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= EMPTY;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      out_valid_r <= (state_nxt_s == FULL);
    end
  end

  // Data and source registers load only on an accepted input word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_r <= 8'h00;
      sel_r <= 1'b0;
    end else if (take_s) begin
      out_r <= grant_idx_s ? a1 : a0;
      sel_r <= grant_idx_s;
    end
  end

  assign out       = out_r;
  assign sel       = sel_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_arb_rr_2x8.sv
// Directed bench for arb_rr_2x8 with a scoreboard of expected {sel, out} words.
module tb_arb_rr_2x8;

  logic       clk;
  logic       rst;
  logic [7:0] a0;
  logic       a0_valid;
  logic       a0_ready;
  logic [7:0] a1;
  logic       a1_valid;
  logic       a1_ready;
  logic       sel;
  logic [7:0] out;
  logic       out_valid;
  logic       out_ready;

  int         errors;
  int         checks;
  logic [8:0] sb[$];
  logic       prev_hold;
  logic [8:0] prev_word;

  arb_rr_2x8 dut (
    .clk       (clk),
    .rst       (rst),
    .a0        (a0),
    .a0_valid  (a0_valid),
    .a0_ready  (a0_ready),
    .a1        (a1),
    .a1_valid  (a1_valid),
    .a1_ready  (a1_ready),
    .sel       (sel),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Protocol monitor and scoreboard consumer, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
      chk("rst_ready0", {15'd0, a0_ready}, 16'd0);
      chk("rst_ready1", {15'd0, a1_ready}, 16'd0);
    end else begin
      chk("one_hot_ready", {15'd0, a0_ready & a1_ready}, 16'd0);
      if (prev_hold) begin
        chk("hold_word", {7'd0, sel, out}, {7'd0, prev_word});
        chk("hold_valid", {15'd0, out_valid}, 16'd1);
      end
      prev_hold = out_valid & ~out_ready;
      prev_word = {sel, out};
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected", {7'd0, sel, out}, 16'hFFFF);
        end else begin
          chk("sb_word", {7'd0, sel, out}, {7'd0, sb.pop_front()});
        end
      end
    end
  end

  initial begin
    logic exp_idx;
    errors    = 0;
    checks    = 0;
    prev_hold = 1'b0;
    prev_word = 9'd0;
    rst       = 1'b1;
    a0        = 8'h00;
    a0_valid  = 1'b1;
    a1        = 8'h00;
    a1_valid  = 1'b0;
    out_ready = 1'b0;

    // Reset state before any clock edge.
    #2;
    chk("reset_out", {8'd0, out}, 16'h0000);
    chk("reset_sel", {15'd0, sel}, 16'd0);
    chk("reset_valid", {15'd0, out_valid}, 16'd0);
    chk("reset_a0_ready", {15'd0, a0_ready}, 16'd0);

    // Single source, accepted on the first edge after reset release.
    step();
    rst       = 1'b0;
    a0        = 8'h11;
    a0_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("single_a0_ready", {15'd0, a0_ready}, 16'd1);
    chk("single_a1_ready", {15'd0, a1_ready}, 16'd0);
    sb.push_back({1'b0, 8'h11});
    step();
    a0_valid = 1'b0;
    @(negedge clk);
    chk("single_valid", {15'd0, out_valid}, 16'd1);
    chk("single_out", {8'd0, out}, 16'h0011);
    chk("single_sel", {15'd0, sel}, 16'd0);
    step();
    @(negedge clk);
    chk("single_drain_valid", {15'd0, out_valid}, 16'd0);
    chk("single_drain_out", {8'd0, out}, 16'h0011);

    // Backpressure: hold 8'h22 while A1 waits, then accept with no bubble.
    step();
    a0        = 8'h22;
    a0_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp_load_ready", {15'd0, a0_ready}, 16'd1);
    sb.push_back({1'b0, 8'h22});
    step();
    a0_valid = 1'b0;
    a1       = 8'h33;
    a1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_out", {8'd0, out}, 16'h0022);
      chk("bp_a1_ready", {15'd0, a1_ready}, 16'd0);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", {15'd0, a1_ready}, 16'd1);
    sb.push_back({1'b1, 8'h33});
    step();
    a1_valid = 1'b0;
    @(negedge clk);
    chk("bp_nobubble_valid", {15'd0, out_valid}, 16'd1);
    chk("bp_nobubble_out", {7'd0, sel, out}, {7'd0, 1'b1, 8'h33});
    step();
    @(negedge clk);
    chk("bp_drain_valid", {15'd0, out_valid}, 16'd0);

    // Streaming from A1 at one word per cycle.
    step();
    for (int i = 0; i <= 10; i++) begin
      a1       = i[7:0];
      a1_valid = (i < 10);
      @(negedge clk);
      if (i < 10) begin
        chk("stream_ready", {15'd0, a1_ready}, 16'd1);
        sb.push_back({1'b1, i[7:0]});
      end
      if (i > 0) begin
        chk("stream_valid", {15'd0, out_valid}, 16'd1);
        chk("stream_word", {7'd0, sel, out}, {7'd0, 1'b1, 8'(i - 1)});
      end
      step();
    end

    // Asynchronous reset mid-cycle while holding 8'h5A.
    a1_valid  = 1'b0;
    a0        = 8'h5A;
    a0_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("rst_load_ready", {15'd0, a0_ready}, 16'd1);
    sb.push_back({1'b0, 8'h5A});
    step();
    a0_valid = 1'b0;
    @(negedge clk);
    chk("rst_pre_out", {8'd0, out}, 16'h005A);
    chk("rst_pre_valid", {15'd0, out_valid}, 16'd1);
    #2;
    a0_valid  = 1'b1;
    out_ready = 1'b1;
    rst       = 1'b1;
    #1;
    chk("rst_async_out", {8'd0, out}, 16'h0000);
    chk("rst_async_sel", {15'd0, sel}, 16'd0);
    chk("rst_async_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_async_ready", {14'd0, a1_ready, a0_ready}, 16'd0);
    sb.delete();
    @(negedge clk);
    step();

    // Contention from a fresh reset: alternation, or A0 only with fixed priority.
    rst      = 1'b0;
    a0       = 8'hA0;
    a1       = 8'hA1;
    a0_valid = 1'b1;
    a1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_FIXED_PRIO_EN
      exp_idx = 1'b0;
`else
      exp_idx = i[0];
`endif
      @(negedge clk);
      chk("cont_a0_ready", {15'd0, a0_ready}, {15'd0, ~exp_idx});
      chk("cont_a1_ready", {15'd0, a1_ready}, {15'd0, exp_idx});
      sb.push_back({exp_idx, exp_idx ? 8'hA1 : 8'hA0});
      if (i > 0) begin
        chk("cont_valid", {15'd0, out_valid}, 16'd1);
      end
      step();
    end
    a0_valid = 1'b0;
    a1_valid = 1'b0;
    @(negedge clk);
    chk("cont_last_valid", {15'd0, out_valid}, 16'd1);
    step();
    @(negedge clk);
    chk("cont_drain_valid", {15'd0, out_valid}, 16'd0);
    chk("sb_empty", 16'(sb.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Time limit so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/arb_rr_2x8.md
ARB_RR_2X8 -- requirements
Module: arb_rr_2x8

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 8 bits.
REQ-002 CLK  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 A0  input  8  data, source 0.
REQ-005 A0_VALID  input  1  source 0 offers A0.
REQ-006 A0_READY  output  1  block accepts A0 this cycle.
REQ-007 A1  input  8  data, source 1.
REQ-008 A1_VALID  input  1  source 1 offers A1.
REQ-009 A1_READY  output  1  block accepts A1 this cycle.
REQ-010 SEL  output  1  select for the downstream 8-bit 2:1 multiplexor; 0 = A0, 1 = A1; source of the word held in OUT.
REQ-011 OUT  output  8  registered data word.
REQ-012 OUT_VALID  output  1  OUT holds an undelivered word.
REQ-013 OUT_READY  input  1  consumer takes OUT this cycle.

Function
REQ-014 A transfer on channel k SHALL occur on a rising edge where Ak_VALID and Ak_READY are both high; the output transfer SHALL occur where OUT_VALID and OUT_READY are both high.
REQ-015 The block SHALL hold a two-state FSM: EMPTY (OUT_VALID=0) and FULL (OUT_VALID=1); OUT_VALID SHALL be a direct register output.
REQ-016 Slot free condition (LOAD_OK) SHALL be: state EMPTY, or state FULL with OUT_READY high the same cycle.
REQ-017 Grant SHALL be combinational: only A0 valid -> grant 0; only A1 valid -> grant 1; both valid -> grant to the priority pointer PTR; neither -> no grant.
REQ-018 Ak_READY SHALL equal LOAD_OK AND grant==k; at most one READY SHALL be high in any cycle; READY SHALL NOT be high for a channel whose VALID is low.
REQ-019 On an input transfer from channel k, OUT SHALL load Ak, SEL SHALL load k, and the FSM SHALL enter/remain FULL, with one-cycle latency (word visible on OUT the cycle after acceptance).
REQ-020 Simultaneous output transfer and input transfer in FULL SHALL replace OUT with the new word with no bubble; FSM stays FULL.
REQ-021 Output transfer without input transfer SHALL move FULL -> EMPTY; OUT and SEL SHALL retain their last values.
REQ-022 In FULL with OUT_READY low, OUT, SEL and OUT_VALID SHALL be held stable and both READY outputs SHALL be low.
REQ-023 PTR SHALL update only on an input transfer: after accepting channel k, PTR SHALL become the other channel (round robin).
REQ-024 Sustained throughput SHALL be one word per cycle when OUT_READY is held high.
REQ-025 An input VALID dropping without a transfer SHALL have no effect on state.

Reset
REQ-026 While RST is high, independent of CLK: OUT=8'h00, SEL=0, OUT_VALID=0, FSM=EMPTY, PTR=0.
REQ-027 A0_READY and A1_READY SHALL be low while RST is high.
REQ-028 Reset asserted mid-transfer SHALL discard the held word; no transfer SHALL be reported on the edge where RST is high.
REQ-029 The first edge after RST deasserts SHALL be able to accept a word.

Configuration
REQ-030 Macro ARB_FIXED_PRIO_EN: when defined, both-valid grant SHALL always go to channel 0 and PTR SHALL be absent; when undefined, round robin per REQ-017/REQ-023 SHALL apply.

Verification
REQ-031 Reset: assert RST asynchronously mid-cycle with OUT=8'h5A FULL -> OUT=8'h00, SEL=0, OUT_VALID=0, both READY low immediately.
REQ-032 Single source: A0=8'h11 valid one cycle, OUT_READY=1 -> next cycle OUT=8'h11, SEL=0, OUT_VALID=1; following cycle OUT_VALID=0, OUT still 8'h11.
REQ-033 Contention, macro undefined: A0=8'hA0, A1=8'hA1 both valid for 4 cycles, OUT_READY=1 -> OUT sequence A0,A1,A0,A1 with SEL 0,1,0,1; with ARB_FIXED_PRIO_EN -> A0 four times, SEL always 0, A1_READY never high.
REQ-034 Backpressure: OUT FULL with 8'h22, OUT_READY=0 for 3 cycles, A1 valid -> OUT stays 8'h22, A1_READY=0; OUT_READY rises -> A1 accepted same cycle, OUT=A1 next cycle, no bubble.
REQ-035 Streaming: A1 valid with incrementing data 8'h00..8'h09, OUT_READY=1 -> ten consecutive OUT_VALID cycles, data 8'h00..8'h09 in order, SEL=1.
REQ-036 Protocol check throughout all scenarios: A0_READY and A1_READY never high together; OUT stable while OUT_VALID=1 and OUT_READY=0.
